// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction fetch stage: instruction width,
// NOP encoding and the sequential PC step.
package if_stage_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_INC  = 32'd4;

  // Byte-offset form of a sign-extended word offset; wraps modulo 2^32.
  function automatic logic [31:0] word_to_byte(input logic [31:0] word_off);
    return word_off << 2;
  endfunction

endpackage

// File: rtl/if_stage_imem.sv
// Instruction ROM: combinational word read; contents are written into mem
// by the environment.
module instruction_memory
  import if_stage_pkg::*;
#(
  parameter int    IMEM_WORDS = 1024,
  parameter string INIT_FILE  = "",
  localparam int   AW         = $clog2(IMEM_WORDS)
) (
  input  logic [AW-1:0]      addr,
  output logic [INSTR_W-1:0] data
);

  logic [INSTR_W-1:0] mem [IMEM_WORDS];

  assign data = mem[addr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, branch redirect with a single bubble,
// IF/ID pipeline register and accepted-instruction counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brTaken,
  input  logic [31:0]         brOffset,
  output logic [31:0]         PC,
  output logic [INSTR_W-1:0]  instruction,
  output logic                valid,
  output logic [31:0]         fetch_count
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0]        pc_q;
  logic [31:0]        pc_next_seq;
  logic [31:0]        br_target;
  logic [INSTR_W-1:0] imem_word;

  instruction_memory #(
    .IMEM_WORDS (IMEM_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_imem (
    .addr (pc_q[AW+1:2]),
    .data (imem_word)
  );

  assign pc_next_seq = pc_q + PC_INC;
  // Target is relative to the PC+4 currently presented to decode.
  assign br_target   = PC + word_to_byte(brOffset);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      PC          <= 32'h0;
      instruction <= NOP;
      valid       <= 1'b0;
      fetch_count <= 32'h0;
    end else if (freeze) begin
      pc_q        <= pc_q;
      PC          <= PC;
      instruction <= instruction;
      valid       <= valid;
      fetch_count <= fetch_count;
    end else if (brTaken) begin
      pc_q        <= br_target;
      PC          <= 32'h0;
      instruction <= NOP;
      valid       <= 1'b0;
      fetch_count <= fetch_count;
    end else begin
      pc_q        <= pc_next_seq;
      PC          <= pc_next_seq;
      instruction <= imem_word;
      valid       <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued as each
// step is driven and compared once the stage has clocked.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        brTaken = 1'b0;
  logic [31:0] brOffset = 32'h0;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        valid;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  if_stage #(.IMEM_WORDS(1024), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .brTaken     (brTaken),
    .brOffset    (brOffset),
    .PC          (PC),
    .instruction (instruction),
    .valid       (valid),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mv(input int i);
    return 32'(i + 100);
  endfunction

  task automatic check(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed PC=%0d", tag, PC);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      tests++;
      assert (PC === e.pc) else begin
        fails++;
        $error("FAIL %s.pc: observed %0d expected %0d", tag, PC, e.pc);
      end
      tests++;
      assert (instruction === e.instr) else begin
        fails++;
        $error("FAIL %s.instr: observed %0d expected %0d", tag, instruction, e.instr);
      end
      tests++;
      assert (valid === e.v) else begin
        fails++;
        $error("FAIL %s.valid: observed %0b expected %0b", tag, valid, e.v);
      end
      tests++;
      assert (fetch_count === e.cnt) else begin
        fails++;
        $error("FAIL %s.count: observed %0d expected %0d", tag, fetch_count, e.cnt);
      end
    end
  endtask

  task automatic cyc(input logic f, input logic b, input logic [31:0] off,
                     input logic [31:0] epc, input logic [31:0] ei,
                     input logic ev, input logic [31:0] ec, input string tag);
    freeze   = f;
    brTaken  = b;
    brOffset = off;
    sb.push_back('{epc, ei, ev, ec});
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Asserts rst between edges, checks the async clear, holds rst across an
  // edge with brTaken driven, then releases it just after that edge.
  task automatic do_reset(input logic b, input string tag);
    rst     = 1'b1;
    brTaken = b;
    brOffset = 32'd5;
    freeze  = 1'b0;
    #2;
    sb.push_back('{32'h0, NOP, 1'b0, 32'h0});
    check({tag, "_async"});
    @(posedge clk);
    #1;
    sb.push_back('{32'h0, NOP, 1'b0, 32'h0});
    check({tag, "_held"});
    rst     = 1'b0;
    brTaken = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = mv(i);
    #1;
    do_reset(1'b0, "por");

    // Free-running fetch
    cyc(0, 0, 0, 32'd4,  mv(0), 1, 1, "run0");
    cyc(0, 0, 0, 32'd8,  mv(1), 1, 2, "run1");
    cyc(0, 0, 0, 32'd12, mv(2), 1, 3, "run2");
    cyc(0, 0, 0, 32'd16, mv(3), 1, 4, "run3");

    // Freeze for three cycles at PC=8
    do_reset(1'b1, "rst_frz");
    cyc(0, 0, 0, 32'd4,  mv(0), 1, 1, "frz_a");
    cyc(0, 0, 0, 32'd8,  mv(1), 1, 2, "frz_b");
    cyc(1, 0, 0, 32'd8,  mv(1), 1, 2, "frz0");
    cyc(1, 0, 0, 32'd8,  mv(1), 1, 2, "frz1");
    cyc(1, 0, 0, 32'd8,  mv(1), 1, 2, "frz2");
    cyc(0, 0, 0, 32'd12, mv(2), 1, 3, "frz_rel");

    // Forward branch, offset 5 words from PC=8 -> byte 28
    do_reset(1'b0, "rst_br");
    cyc(0, 0, 0,     32'd4,  mv(0), 1, 1, "br_a");
    cyc(0, 0, 0,     32'd8,  mv(1), 1, 2, "br_b");
    cyc(0, 1, 32'd5, 32'd0,  NOP,   0, 2, "br_bubble");
    cyc(0, 0, 0,     32'd32, mv(7), 1, 3, "br_tgt");
    cyc(0, 0, 0,     32'd36, mv(8), 1, 4, "br_next");

    // Backward branch, -2 words from PC=16 -> byte 8
    do_reset(1'b0, "rst_bk");
    cyc(0, 0, 0,            32'd4,  mv(0), 1, 1, "bk_a");
    cyc(0, 0, 0,            32'd8,  mv(1), 1, 2, "bk_b");
    cyc(0, 0, 0,            32'd12, mv(2), 1, 3, "bk_c");
    cyc(0, 0, 0,            32'd16, mv(3), 1, 4, "bk_d");
    cyc(0, 1, 32'hFFFF_FFFE, 32'd0, NOP,   0, 4, "bk_bubble");
    cyc(0, 0, 0,            32'd12, mv(2), 1, 5, "bk_tgt");

    // Freeze overrides branch; redirect on first unfrozen branch cycle
    do_reset(1'b0, "rst_fb");
    cyc(0, 0, 0,     32'd4,  mv(0), 1, 1, "fb_a");
    cyc(0, 0, 0,     32'd8,  mv(1), 1, 2, "fb_b");
    cyc(1, 1, 32'd5, 32'd8,  mv(1), 1, 2, "fb_hold0");
    cyc(1, 1, 32'd5, 32'd8,  mv(1), 1, 2, "fb_hold1");
    cyc(0, 1, 32'd5, 32'd0,  NOP,   0, 2, "fb_bubble");
    cyc(0, 0, 0,     32'd32, mv(7), 1, 3, "fb_tgt");

    // Reset during a branch bubble discards the pending target
    do_reset(1'b0, "rst_mb");
    cyc(0, 0, 0,     32'd4, mv(0), 1, 1, "mb_a");
    cyc(0, 0, 0,     32'd8, mv(1), 1, 2, "mb_b");
    cyc(0, 1, 32'd5, 32'd0, NOP,   0, 2, "mb_bubble");
    #2;
    do_reset(1'b1, "mb_rst");
    cyc(0, 0, 0,     32'd4, mv(0), 1, 1, "mb_restart");
    cyc(0, 0, 0,     32'd8, mv(1), 1, 2, "mb_restart2");

    // Fetch index wraps past the last word; target wraps modulo 2^32
    do_reset(1'b0, "rst_wr");
    cyc(0, 0, 0,             32'd4,    mv(0),    1, 1, "wr_a");
    cyc(0, 1, 32'd1022,      32'd0,    NOP,      0, 1, "wr_bubble");
    cyc(0, 0, 0,             32'd4096, mv(1023), 1, 2, "wr_last");
    cyc(0, 0, 0,             32'd4100, mv(0),    1, 3, "wr_idx");
    cyc(0, 0, 0,             32'd4104, mv(1),    1, 4, "wr_idx1");
    do_reset(1'b0, "rst_ov");
    cyc(0, 0, 0,             32'd4,    mv(0),    1, 1, "ov_a");
    cyc(0, 1, 32'h3FFF_FFFF, 32'd0,    NOP,      0, 1, "ov_bubble");
    cyc(0, 0, 0,             32'd4,    mv(0),    1, 2, "ov_tgt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port freeze  input  1: hazard stall; hold PC and the IF/ID register.
REQ-006 Port brTaken  input  1: decode stage has resolved a taken branch this cycle.
REQ-007 Port brOffset  input  32: sign-extended word offset of the branch in decode.
REQ-008 Port PC  output  32: registered PC+4 of the instruction held in IF/ID.
REQ-009 Port instruction  output  32: registered instruction word held in IF/ID.
REQ-010 Port valid  output  1: IF/ID holds a real fetched instruction, not a bubble.
REQ-011 Port fetch_count  output  32: number of instructions accepted into IF/ID since reset.

Function
REQ-012 Internal fetch PC: byte address; fetch word index is pc_q[log2(IMEM_WORDS)+1:2]; pc_q[1:0] always 0.
REQ-013 Instruction memory read is combinational from pc_q; no read latency.
REQ-014 Priority per cycle: rst > freeze > brTaken > normal advance.
REQ-015 Normal (freeze=0, brTaken=0): pc_q <= pc_q+4; PC <= pc_q+4; instruction <= imem word; valid <= 1; fetch_count +1.
REQ-016 Freeze=1: pc_q, PC, instruction, valid, fetch_count all hold; brTaken ignored that cycle.
REQ-017 Branch (freeze=0, brTaken=1): pc_q <= PC + (brOffset << 2), using current IF/ID PC output; instruction <= 32'h0; valid <= 0; PC <= 0; fetch_count holds.
REQ-018 Branch penalty exactly one bubble; the target instruction appears in IF/ID on the second edge after brTaken is sampled.
REQ-019 Target arithmetic is 32-bit modulo; overflow wraps silently.
REQ-020 PC increment wraps modulo 2^32; fetch index wraps modulo IMEM_WORDS.
REQ-021 fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-022 Instruction 32'h0 is the pipeline NOP; consumers treat valid=0 as bubble regardless of encoding.

Reset
REQ-023 On rst assertion, immediately and independent of clk: pc_q=RESET_PC, PC=0, instruction=0, valid=0, fetch_count=0.
REQ-024 While rst is high all inputs are ignored; first fetch from RESET_PC occurs on the first rising edge after rst deasserts.
REQ-025 Reset mid-branch or mid-freeze discards pending target and stall state.

Structure
REQ-026 Shared package holds NOP encoding 32'h0, instruction width 32, and PC increment 4.
REQ-027 Memory is a sub-module named instruction_memory (parameter IMEM_WORDS, word-address input, combinational 32-bit output, contents loaded from a hex file).
REQ-028 PC register, target adder, IF/ID register and fetch counter reside in if_stage.

Verification
REQ-029 Reset, then 4 free-running cycles, imem[i]=i+100 -> PC=4,8,12,16; instruction=100,101,102,103; valid=1; fetch_count=4.
REQ-030 freeze=1 for 3 cycles after PC=8 -> PC stays 8, instruction stays 101, fetch_count stays 2; resumes at PC=12 on release.
REQ-031 brTaken=1, brOffset=5 while PC=8 -> next cycle valid=0, instruction=0; following cycle PC=32, instruction=imem[7].
REQ-032 brOffset=32'hFFFF_FFFE while PC=16 -> fetch resumes from byte 8; instruction=imem[2].
REQ-033 freeze=1 and brTaken=1 together -> full hold, no redirect; redirect occurs on the first cycle with freeze=0 and brTaken=1.
REQ-034 rst asserted between clock edges during a branch bubble -> outputs at reset values before next edge; fetch restarts at RESET_PC.
